// File: rtl/instr_deserializer_pkg.sv
// Shared widths, frame layout and lane encoding for the instruction deserializer.
// The frame is shifted in MSB first: opcode, key_addr, text_addr, dest_addr.
`timescale 1ns/1ps
package instr_deserializer_pkg;

    localparam int ADDRW      = 24;
    localparam int OPCODEW    = 2;
    localparam int INSTRW     = 3*ADDRW + OPCODEW;
    localparam int OP_SEL_BIT = 0;
    localparam int CNTW       = $clog2(INSTRW + 1);

    typedef enum logic {
        LANE_AES = 1'b0,
        LANE_SHA = 1'b1
    } lane_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPCODEW-1:0] opcode;
        logic [ADDRW-1:0]   key_addr;
        logic [ADDRW-1:0]   text_addr;
        logic [ADDRW-1:0]   dest_addr;
    } frame_t;

    function automatic lane_e frame_lane(input frame_t f);
        return lane_e'(f.opcode[OP_SEL_BIT]);
    endfunction

endpackage

// File: rtl/instr_deserializer_sync_edge.sv
// Brings the asynchronous SPI pins into clk with 2-FF synchronizers and
// flags the rising edge of the synchronized sclk.
`timescale 1ns/1ps
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    // Presets match an idle bus: sclk low, chip select deasserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_n_sync = cs_q[1];
    assign mosi_sync = mosi_q[1];

endmodule

// File: rtl/instr_deserializer.sv
// SPI mode-0 slave that assembles one instruction frame and offers it to the
// request queue from a one-entry holding register.
//
// state | meaning
// IDLE  | waiting for chip select to fall
// SHIFT | shifting frame bits on each sclk rise
// DONE  | frame complete, waiting for chip select to rise
`timescale 1ns/1ps
module instr_deserializer
    import instr_deserializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_sclk,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    input  logic               ready_in_aes,
    input  logic               ready_in_sha,
    output logic               valid_out,
    output logic [OPCODEW-1:0] opcode,
    output logic [ADDRW-1:0]   key_addr,
    output logic [ADDRW-1:0]   text_addr,
    output logic [ADDRW-1:0]   dest_addr,
    output logic               frame_drop,
    output logic               frame_err,
    output logic               busy
);

    logic sclk_rise;
    logic cs_n_sync;
    logic mosi_sync;

    spi_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (spi_sclk),
        .cs_n      (spi_cs_n),
        .mosi      (spi_mosi),
        .sclk_rise (sclk_rise),
        .cs_n_sync (cs_n_sync),
        .mosi_sync (mosi_sync)
    );

    state_e            state, state_nxt;
    logic [CNTW-1:0]   count, count_nxt;
    logic [INSTRW-1:0] shreg, shreg_nxt;
    logic              complete, complete_nxt;
    logic              err, err_nxt;
    logic              extra_seen, extra_nxt;
    logic [1:0]        settle_cnt;
    logic              armed;

    // The synchronizers come out of reset preset to idle, so cs_n only counts
    // once a genuine high has been sampled; a chip select that was already low
    // across reset cannot start a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != 2'd2)
                settle_cnt <= settle_cnt + 2'd1;
            if (settle_cnt == 2'd2 && cs_n_sync)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            shreg      <= '0;
            complete   <= 1'b0;
            err        <= 1'b0;
            extra_seen <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            shreg      <= shreg_nxt;
            complete   <= complete_nxt;
            err        <= err_nxt;
            extra_seen <= extra_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        shreg_nxt    = shreg;
        complete_nxt = 1'b0;
        err_nxt      = 1'b0;
        extra_nxt    = extra_seen;
        case (state)
            ST_IDLE: begin
                if (armed && !cs_n_sync) begin
                    state_nxt = ST_SHIFT;
                    count_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_n_sync) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = (count != '0);
                    count_nxt = '0;
                end else if (sclk_rise) begin
                    shreg_nxt = {shreg[INSTRW-2:0], mosi_sync};
                    count_nxt = count + CNTW'(1);
                    if (count == CNTW'(INSTRW - 1)) begin
                        state_nxt    = ST_DONE;
                        complete_nxt = 1'b1;
                        extra_nxt    = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                // Overrun bits are reported once but the completed frame stands.
                if (cs_n_sync) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else if (sclk_rise && !extra_seen) begin
                    err_nxt   = 1'b1;
                    extra_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    frame_t hold;
    logic   hold_valid;
    logic   drop;
    logic   sel_ready;
    logic   drain;

    assign sel_ready = (frame_lane(hold) == LANE_SHA) ? ready_in_sha : ready_in_aes;
    assign drain     = hold_valid && sel_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            drop       <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (complete) begin
                if (!hold_valid || drain) begin
                    hold       <= shreg;
                    hold_valid <= 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign valid_out  = hold_valid;
    assign opcode     = hold.opcode;
    assign key_addr   = hold.key_addr;
    assign text_addr  = hold.text_addr;
    assign dest_addr  = hold.dest_addr;
    assign frame_drop = drop;
    assign frame_err  = err;
    assign busy       = ~cs_n_sync;

endmodule

// File: tb/tb_instr_deserializer.sv
// Directed bench for instr_deserializer: frames, backpressure, drops,
// short/long frames and reset mid-frame, each against hand-built expectations.
`timescale 1ns/1ps
module tb_instr_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        ready_in_aes = 1'b0;
    logic        ready_in_sha = 1'b0;
    logic        valid_out;
    logic [1:0]  opcode;
    logic [23:0] key_addr;
    logic [23:0] text_addr;
    logic [23:0] dest_addr;
    logic        frame_drop;
    logic        frame_err;
    logic        busy;

    instr_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .ready_in_aes (ready_in_aes),
        .ready_in_sha (ready_in_sha),
        .valid_out    (valid_out),
        .opcode       (opcode),
        .key_addr     (key_addr),
        .text_addr    (text_addr),
        .dest_addr    (dest_addr),
        .frame_drop   (frame_drop),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor, sampled on the falling clock edge
    int          cyc = 0;
    int          last_rise_cyc = 0;
    int          valid_rise_cyc = -100;
    int          valid_cycles = 0;
    int          drop_cnt = 0;
    int          err_cnt = 0;
    logic        valid_d = 1'b0;
    logic [73:0] cap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out && !valid_d) valid_rise_cyc = cyc;
        valid_d = valid_out;
        if (valid_out) valid_cycles++;
        if (valid_out && (opcode[0] ? ready_in_sha : ready_in_aes))
            cap_q.push_back({opcode, key_addr, text_addr, dest_addr});
        if (frame_drop) drop_cnt++;
        if (frame_err) err_cnt++;
    end

    function automatic logic [73:0] last_cap();
        if (cap_q.size() == 0) return 'x;
        return cap_q[cap_q.size()-1];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bits(input logic [73:0] f, input int nedges);
        for (int i = 0; i < nedges; i++) begin
            if (i < 74) spi_mosi = f[73-i];
            else        spi_mosi = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [73:0] f, input int nedges);
        spi_cs_n = 1'b0;
        wait_clk(6);
        spi_bits(f, nedges);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
    endtask

    localparam logic [73:0] F1  = {2'b00, 24'h000100, 24'h000200, 24'h000300};
    localparam logic [73:0] F2  = {2'b01, 24'hA5A5A5, 24'h123456, 24'hFEDCBA};
    localparam logic [73:0] F3A = {2'b01, 24'h111111, 24'h222222, 24'h333333};
    localparam logic [73:0] F3B = {2'b11, 24'h444444, 24'h555555, 24'h666666};
    localparam logic [73:0] F3C = {2'b01, 24'h777777, 24'h888888, 24'h999999};
    localparam logic [73:0] FJ  = {2'b10, 24'h5A5A5A, 24'hA5A5A5, 24'h0F0F0F};
    localparam logic [73:0] F4  = {2'b00, 24'hC0FFEE, 24'h0BADF0, 24'h00D00D};
    localparam logic [73:0] F5  = {2'b10, 24'hABCDEF, 24'h13579B, 24'h2468AC};
    localparam logic [73:0] F6  = {2'b11, 24'hDEADBE, 24'hCAFEBA, 24'hF00D12};

    initial begin
        #500us;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          vc0, dc0, ec0, nc0;
        logic [73:0] f_rest;

        // reset
        wait_clk(3);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop_err", {frame_drop, frame_err}, 2'b00);
        chk("rst_fields", {opcode, key_addr, text_addr, dest_addr}, 74'd0);
        rst = 1'b0;
        wait_clk(5);

        // plain AES frame: latency and single-cycle valid
        ready_in_aes = 1'b1;
        ready_in_sha = 1'b1;
        vc0 = valid_cycles;
        spi_cs_n = 1'b0;
        wait_clk(6);
        chk("t1_busy_hi", busy, 1'b1);
        spi_bits(F1, 74);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("t1_busy_lo", busy, 1'b0);
        chk("t1_latency", valid_rise_cyc - last_rise_cyc, 4);
        chk("t1_valid_cycles", valid_cycles - vc0, 1);
        chk("t1_count", cap_q.size(), 1);
        chk("t1_fields", last_cap(), F1);
        chk("t1_valid_lo", valid_out, 1'b0);

        // SHA frame held by backpressure while the AES lane is ready
        ready_in_sha = 1'b0;
        nc0 = cap_q.size();
        send_frame(F2, 74);
        for (int i = 0; i < 20; i++) begin
            chk("t2_hold", {valid_out, opcode, key_addr, text_addr, dest_addr}, {1'b1, F2});
            wait_clk(1);
        end
        chk("t2_no_xfer", cap_q.size(), nc0);
        ready_in_sha = 1'b1;
        wait_clk(1);
        chk("t2_valid_lo", valid_out, 1'b0);
        chk("t2_count", cap_q.size(), nc0 + 1);
        chk("t2_fields", last_cap(), F2);

        // holding register full: second frame dropped, third accepted
        ready_in_sha = 1'b0;
        dc0 = drop_cnt;
        send_frame(F3A, 74);
        send_frame(F3B, 74);
        chk("t3_drop", drop_cnt - dc0, 1);
        chk("t3_held", {valid_out, opcode, key_addr, text_addr, dest_addr}, {1'b1, F3A});
        ready_in_sha = 1'b1;
        wait_clk(2);
        chk("t3_first_out", last_cap(), F3A);
        chk("t3_valid_lo", valid_out, 1'b0);
        send_frame(F3C, 74);
        chk("t3_third_out", last_cap(), F3C);
        chk("t3_drop_once", drop_cnt - dc0, 1);

        // short frame (40 bits) then a good frame
        ec0 = err_cnt;
        vc0 = valid_cycles;
        nc0 = cap_q.size();
        spi_cs_n = 1'b0;
        wait_clk(6);
        spi_bits(FJ, 40);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("t4_err", err_cnt - ec0, 1);
        chk("t4_no_valid", valid_cycles - vc0, 0);
        chk("t4_no_cap", cap_q.size(), nc0);
        send_frame(F4, 74);
        chk("t4_next_frame", last_cap(), F4);
        chk("t4_err_once", err_cnt - ec0, 1);

        // 76 edges: first 74 bits kept, one error
        ec0 = err_cnt;
        vc0 = valid_cycles;
        send_frame(F5, 76);
        chk("t5_err", err_cnt - ec0, 1);
        chk("t5_valid_cycles", valid_cycles - vc0, 1);
        chk("t5_fields", last_cap(), F5);

        // reset at bit 30 with cs_n held low
        ec0 = err_cnt;
        vc0 = valid_cycles;
        nc0 = cap_q.size();
        spi_cs_n = 1'b0;
        wait_clk(6);
        spi_bits(F6, 30);
        rst = 1'b1;
        wait_clk(2);
        chk("t6_rst_outs", {valid_out, busy, frame_err, frame_drop}, 4'b0000);
        rst = 1'b0;
        f_rest = F6 << 30;
        spi_bits(f_rest, 44);
        wait_clk(10);
        chk("t6_no_valid", valid_cycles - vc0, 0);
        chk("t6_no_err", err_cnt - ec0, 0);
        spi_cs_n = 1'b1;
        wait_clk(10);
        chk("t6_no_cap", cap_q.size(), nc0);
        send_frame(F6, 74);
        chk("t6_count", cap_q.size(), nc0 + 1);
        chk("t6_fields", last_cap(), F6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
